// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter and the MEM-stage alignment logic.
// Holds the RV32I load/store size encodings, the owner tag and the arbiter state encoding.
package rv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_align_check.sv
// Combinational RV32I alignment check: flags word accesses off a 4-byte boundary and
// halfword accesses off a 2-byte boundary. No state, zero latency, no flow control.
module mem_align_check (
  input  logic [2:0] funct3_i,
  input  logic [1:0] addr_lo_i,
  output logic       misalign_o
);
  import rv32_mem_pkg::*;

  always_comb begin
    misalign_o = 1'b0;
    case (funct3_i)
      F3_W:       misalign_o = |addr_lo_i;
      F3_H, F3_HU: misalign_o = addr_lo_i[0];
      default:    misalign_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the data stage; result returns
// MEM_LATENCY+1 cycles after the same-cycle grant, and a requester stalls until its rvalid pulse.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [2:0]        dm_funct3,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_misalign,
  output logic              mem_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import rv32_mem_pkg::*;

  localparam int CNT_W = $clog2(MEM_LATENCY + 2);
  localparam int STK_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MEM_LATENCY);
  localparam logic [STK_W-1:0] STREAK_MAX = STK_W'(STARVE_MAX);

  arb_state_t        state_q;
  owner_t            owner_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [STK_W-1:0]  streak_q, streak_d;
  logic              flush_q;
  logic              misalign_q;
  logic              dm_we_q;

  logic              mem_en_q, mem_we_q;
  logic [2:0]        mem_funct3_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_rvalid_q, dm_rvalid_q, dm_misalign_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

  logic dm_mis;
  logic if_elig, dm_elig, can_grant, pick_if;

  mem_align_check u_align (
    .funct3_i   (dm_funct3),
    .addr_lo_i  (dm_addr[1:0]),
    .misalign_o (dm_mis)
  );

  // A port whose rvalid is high still holds req for the access that just finished.
  assign if_elig   = if_req & ~if_rvalid_q;
  assign dm_elig   = dm_req & ~dm_rvalid_q;
  assign can_grant = ~rst & enable & (state_q == ARB_IDLE);
  assign pick_if   = if_elig & (~dm_elig | (streak_q == STREAK_MAX));
  assign if_gnt    = can_grant & pick_if;
  assign dm_gnt    = can_grant & dm_elig & ~pick_if;

  always_comb begin
    streak_d = streak_q;
    if (!if_req || if_gnt) begin
      streak_d = '0;
    end else if (dm_gnt && if_elig && streak_q != STREAK_MAX) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      owner_q       <= OWN_NONE;
      cnt_q         <= '0;
      streak_q      <= '0;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
      dm_we_q       <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_funct3_q  <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      if_rvalid_q   <= 1'b0;
      if_rdata_q    <= '0;
      dm_rvalid_q   <= 1'b0;
      dm_rdata_q    <= '0;
      dm_misalign_q <= 1'b0;
    end else begin
      // Strobe and completion outputs are single-cycle pulses; mem_* read as zero when idle.
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_funct3_q  <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      if_rvalid_q   <= 1'b0;
      if_rdata_q    <= '0;
      dm_rvalid_q   <= 1'b0;
      dm_rdata_q    <= '0;
      dm_misalign_q <= 1'b0;
      streak_q      <= streak_d;

      case (state_q)
        ARB_IDLE: begin
          if (if_gnt || dm_gnt) begin
            state_q    <= ARB_BUSY;
            cnt_q      <= CNT_W'(1);
            owner_q    <= if_gnt ? OWN_IF : OWN_DM;
            flush_q    <= if_gnt & if_flush;
            misalign_q <= dm_gnt & dm_mis;
            dm_we_q    <= dm_we;
            if (if_gnt) begin
              mem_en_q     <= 1'b1;
              mem_funct3_q <= F3_W;
              mem_addr_q   <= if_addr;
            end else if (!dm_mis) begin
              mem_en_q     <= 1'b1;
              mem_we_q     <= dm_we;
              mem_funct3_q <= dm_funct3;
              mem_addr_q   <= dm_addr;
              mem_wdata_q  <= dm_wdata;
            end
          end else begin
            cnt_q <= '0;
          end
        end

        ARB_BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (owner_q == OWN_IF && if_flush) begin
            flush_q <= 1'b1;
          end
          if (cnt_q == CNT_LAST) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_NONE;
            if (owner_q == OWN_IF) begin
              if (!(flush_q || if_flush)) begin
                if_rvalid_q <= 1'b1;
                if_rdata_q  <= mem_rdata;
              end
            end else begin
              dm_rvalid_q   <= 1'b1;
              dm_misalign_q <= misalign_q;
              dm_rdata_q    <= (misalign_q || dm_we_q) ? '0 : mem_rdata;
            end
          end
        end

        default: begin
          state_q <= ARB_IDLE;
          owner_q <= OWN_NONE;
        end
      endcase
    end
  end

  assign if_rvalid   = if_rvalid_q;
  assign if_rdata    = if_rdata_q;
  assign dm_rvalid   = dm_rvalid_q;
  assign dm_rdata    = dm_rdata_q;
  assign dm_misalign = dm_misalign_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_funct3  = mem_funct3_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

  assign if_stall  = if_req & ~if_rvalid_q;
  assign mem_stall = dm_req & ~dm_rvalid_q;

endmodule
